// File: rtl/pc_ir_unit.sv
// Multicycle datapath front end: program counter, instruction register, memory data
// register, memory address select, instruction field decode and fetch bookkeeping.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        PCSrc,
    input  logic        IRWrite,
    input  logic        lorD,
    input  logic        Zero,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemRdData,
    output logic [31:0] MemAddr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [31:0] SignImm,
    output logic [31:0] Data,
    output logic [31:0] InstrCount,
    output logic        PCMisalign
);

    logic        pc_en;
    logic [31:0] pc_next;
    logic        pc_next_aligned;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic [31:0] instr_count;
    logic        misalign_q;

    assign pc_en           = PCWrite | (Branch & Zero);
    assign pc_next         = PCSrc ? ALUOut : ALUResult;
    assign pc_next_aligned = (pc_next[1:0] == 2'b00);

    // rst_n is active-high despite its name; it keeps the name used elsewhere in the codebase.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            data_q      <= 32'h0;
            instr_count <= 32'h0;
            misalign_q  <= 1'b0;
        end else begin
            if (pc_en) begin
                if (pc_next_aligned) begin
                    pc_q <= pc_next;
                end else begin
                    misalign_q <= 1'b1;
                end
            end
            if (IRWrite) begin
                instr_q     <= MemRdData;
                instr_count <= instr_count + 32'd1;
            end
            data_q <= MemRdData;
        end
    end

    // The address uses the registered PC, so a fetch in the same cycle as a PC update reads the old PC.
    assign MemAddr = lorD ? ALUOut : pc_q;

    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign Data       = data_q;
    assign InstrCount = instr_count;
    assign PCMisalign = misalign_q;

    assign Op      = instr_q[31:26];
    assign Rs      = instr_q[25:21];
    assign Rt      = instr_q[20:16];
    assign Rd      = instr_q[15:11];
    assign Funct   = instr_q[5:0];
    assign SignImm = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-high; the port keeps the codebase name despite the suffix.
REQ-004 SHALL have port PCWrite  input  1  unconditional PC update enable from control.
REQ-005 SHALL have port Branch  input  1  conditional PC update enable, qualified by Zero.
REQ-006 SHALL have port PCSrc  input  1  next-PC select: 0 = ALUResult, 1 = ALUOut.
REQ-007 SHALL have port IRWrite  input  1  instruction register load enable.
REQ-008 SHALL have port lorD  input  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 SHALL have port Zero  input  1  ALU zero flag for the current cycle.
REQ-010 SHALL have port ALUResult  input  32  combinational ALU output, typically PC+4.
REQ-011 SHALL have port ALUOut  input  32  registered ALU output: branch target or data address.
REQ-012 SHALL have port MemRdData  input  32  read data from unified memory.
REQ-013 SHALL have port MemAddr  output  32  unified memory address.
REQ-014 SHALL have port PC  output  32  current program counter.
REQ-015 SHALL have port Instr  output  32  instruction register contents.
REQ-016 SHALL have ports Op, Funct  output  6 each  Instr[31:26] and Instr[5:0], sent to control.
REQ-017 SHALL have ports Rs, Rt, Rd  output  5 each  Instr[25:21], Instr[20:16], Instr[15:11].
REQ-018 SHALL have port SignImm  output  32  Instr[15:0] sign-extended.
REQ-019 SHALL have port Data  output  32  memory data register (MDR).
REQ-020 SHALL have port InstrCount  output  32  number of IR loads since reset.
REQ-021 SHALL have port PCMisalign  output  1  sticky flag for a rejected unaligned PC update.

Function
REQ-022 SHALL compute PCEn = PCWrite | (Branch & Zero).
REQ-023 SHALL compute PCNext = PCSrc ? ALUOut : ALUResult.
REQ-024 SHALL load PC <= PCNext at the edge when PCEn=1 and PCNext[1:0]==2'b00; otherwise PC SHALL hold.
REQ-025 When PCEn=1 and PCNext[1:0]!=0, SHALL hold PC, set PCMisalign=1, and keep it set until reset.
REQ-026 MemAddr SHALL be combinational: lorD ? ALUOut : PC, using the PC value before any same-edge update.
REQ-027 SHALL load Instr <= MemRdData at the edge when IRWrite=1; otherwise Instr SHALL hold.
REQ-028 Data SHALL load MemRdData at every edge, giving one-cycle latency, no enable.
REQ-029 When IRWrite and PCEn are both 1 in one cycle, both SHALL update at the same edge; Instr captures data fetched from the old PC.
REQ-030 InstrCount SHALL increment by 1 at each edge with IRWrite=1 and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 Op, Funct, Rs, Rt, Rd and SignImm SHALL be combinational decodes of the registered Instr, with zero latency after the Instr edge.
REQ-032 SignImm SHALL equal {{16{Instr[15]}}, Instr[15:0]}.
REQ-033 Branch=1 with Zero=0 and PCWrite=0 SHALL leave PC unchanged.

Reset
REQ-034 While rst_n=1 at an edge: PC SHALL be RESET_PC; Instr, Data and InstrCount SHALL be 0; PCMisalign SHALL be 0.
REQ-035 Reset SHALL take priority over PCWrite, Branch and IRWrite in the same cycle, including mid-instruction.
REQ-036 Outputs SHALL be defined from the first edge with rst_n=1; combinational outputs follow the reset register values.

Verification
REQ-037 Fetch: reset, then IRWrite=1, PCWrite=1, PCSrc=0, ALUResult=4, MemRdData=32'h8C22_0008 -> next cycle PC=4, Instr=32'h8C22_0008, Op=6'h23, Rs=1, Rt=2, SignImm=8, InstrCount=1.
REQ-038 Branch taken/not taken: Branch=1, PCSrc=1, ALUOut=32'h40, Zero=1 -> PC=32'h40; same with Zero=0 -> PC holds.
REQ-039 Data access: lorD=1, ALUOut=32'h100 -> MemAddr=32'h100 the same cycle; MemRdData=32'hDEAD_BEEF -> Data=32'hDEAD_BEEF after one edge.
REQ-040 Misalign: PCWrite=1, ALUResult=32'h6 -> PC holds and PCMisalign=1; a later aligned update moves PC while PCMisalign stays 1.
REQ-041 Sign extension and wrap: Instr[15:0]=16'h8000 -> SignImm=32'hFFFF_8000; force InstrCount to 32'hFFFF_FFFF (or run long), then IRWrite -> 0.
REQ-042 Reset mid-operation: rst_n=1 together with PCWrite=1, IRWrite=1 -> PC=RESET_PC, Instr=0, InstrCount=0 after the edge.
